hazard_sched: RTL and testbench
===============================

# hazard_sched

Pipeline hazard scheduler for the 5-stage RISC-V core without forwarding. It keeps a per-register scoreboard of in-flight writebacks and holds IF/ID while the ID-stage instruction reads a pending register. It serializes CSR instructions by draining the pipeline before issuing them, and it applies branch-redirect flushes and memory-wait freezes with a fixed priority. It sits beside the ID stage and drives the IF/ID and ID/EX pipeline-register controls.

## Interface
Parameters:
- LAT, 3, cycles from an instruction leaving ID until its rd write is visible to an ID read; legal range 1..7
- CW, $clog2(LAT+1), scoreboard counter width (derived; do not override)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous and active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  5 each  source register indices
- id_rs1_used, id_rs2_used  in  1 each  the instruction actually reads that source
- id_rd  in  5  destination register index
- id_wen  in  1  the instruction writes rd
- id_csr  in  1  the instruction is a CSR or system instruction and needs serialization
- ex_redirect  in  1  branch or jump taken in EX; the ID/IF contents are wrong-path
- mem_busy  in  1  memory stage waiting; the whole pipeline freezes
- if_stall  out  1  hold PC and IF/ID
- id_stall  out  1  hold the ID instruction
- ex_bubble  out  1  load a NOP into ID/EX
- id_flush  out  1  clear IF/ID to a NOP
- csr_go  out  1  the CSR instruction in ID issues this cycle
- busy  out  1  FSM not IDLE, or any scoreboard counter nonzero

## Operation
- Scoreboard: cnt[1..31], each CW bits. cnt[0] does not exist; x0 is never pending.
- raw = id_valid & ((id_rs1_used & id_rs1!=0 & cnt[id_rs1]!=0) | (id_rs2_used & id_rs2!=0 & cnt[id_rs2]!=0)).
- FSM states: IDLE, DRAIN, EXEC.
- csr_hold = id_valid & id_csr & state!=EXEC.
- Combinational priority, highest first:
  - mem_busy: if_stall=id_stall=1; ex_bubble=id_flush=csr_go=0. Scoreboard and FSM hold.
  - ex_redirect: id_flush=1, ex_bubble=1, if_stall=id_stall=csr_go=0. No issue. Counters decrement. FSM goes to IDLE.
  - raw | csr_hold: if_stall=id_stall=1, ex_bubble=1. No issue. Counters decrement.
  - Otherwise: issue = id_valid; all stall/flush outputs are 0; csr_go = issue & state==EXEC.
- Counter update, when not frozen by mem_busy:
  - Every nonzero cnt decrements by 1.
  - On issue with id_wen & id_rd!=0, cnt[id_rd] <= LAT. The set wins over a same-cycle decrement of that entry.
- FSM transitions:
  - IDLE -> DRAIN when id_valid & id_csr & !mem_busy & !ex_redirect.
  - DRAIN -> EXEC when all cnt==0 (evaluated on the registered counters), unless overridden by the two rules below.
  - DRAIN -> IDLE if id_valid drops.
  - EXEC -> IDLE after a cycle with csr_go=1. EXEC holds under mem_busy; csr_go is forced to 0 while frozen.
  - Any state -> IDLE on ex_redirect, provided mem_busy is low.
- No instruction issues in DRAIN, so the scoreboard drains monotonically. In EXEC the scoreboard is empty, so raw=0.

## Timing
- Reset (async): state=IDLE, all cnt=0. Outputs are combinational: with id_valid=0, mem_busy=0 and ex_redirect=0, every output is 0 and busy=0.
- A reset asserted mid-drain or mid-stall clears state immediately; the instruction in ID then re-evaluates against the empty scoreboard.
- Dependent instruction directly after its producer: exactly LAT stall cycles, and it issues in cycle LAT+1.
- A gap of k cycles between producer and consumer reduces the stall to max(LAT-k, 0) cycles.
- CSR issue latency from arriving in ID: 1 cycle in IDLE, plus the drain cycles until the scoreboard is empty, plus 1 cycle in EXEC.
- busy deasserts the cycle after the last counter reaches 0 with state IDLE.

## Test plan
- LAT=3. Issue rd=5 (id_wen=1), then next cycle rs1=5 used: id_stall=ex_bubble=1 for 3 cycles, issues in cycle 4. Same sequence with rd=0: no stall.
- Producer rd=7, then an unrelated instruction, then a reader of x7: 2 stall cycles. Back-to-back writes to x7 each reload cnt[7]=3.
- ex_redirect=1 during a raw stall: id_flush=1, id_stall=0 that cycle. The flushed reader's rd does not set the scoreboard.
- CSR arrives with cnt[3]=2: FSM IDLE->DRAIN->DRAIN->EXEC; csr_go=1 exactly once, at cycle 3 after arrival; then IDLE.
- mem_busy=1 for 4 cycles with cnt[9]=2: counters frozen at 2, if_stall=1, ex_bubble=0. The counters resume decrementing after release.
- Assert rst in DRAIN with nonzero counters: busy=0 and state IDLE immediately. A CSR still in ID re-enters DRAIN and reaches EXEC the following cycle.

Source files
------------

// File: rtl/hazard_sched.sv
// Hazard scheduler for the 5-stage core: register scoreboard interlock,
// CSR serialization by pipeline drain, and redirect/freeze priority.
module hazard_sched #(
    parameter int LAT = 3,
    parameter int CW  = $clog2(LAT + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] id_rd,
    input  logic       id_wen,
    input  logic       id_csr,
    input  logic       ex_redirect,
    input  logic       mem_busy,
    output logic       if_stall,
    output logic       id_stall,
    output logic       ex_bubble,
    output logic       id_flush,
    output logic       csr_go,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        EXEC  = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_LAT  = CW'(LAT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] cnt_r [31:1];
    logic [31:0]   pend_s;
    logic          sb_empty_s;
    logic          raw_s;
    logic          csr_hold_s;
    logic          issue_s;

    // Pending flags; bit 0 stays clear so x0 never interlocks.
    always_comb begin
        pend_s = 32'd0;
        for (int i = 1; i < 32; i++) begin
            pend_s[i] = (cnt_r[i] != CNT_ZERO);
        end
    end

    assign sb_empty_s = ~|pend_s;
    assign raw_s = id_valid &
                   ((id_rs1_used & (id_rs1 != 5'd0) & pend_s[id_rs1]) |
                    (id_rs2_used & (id_rs2 != 5'd0) & pend_s[id_rs2]));
    assign csr_hold_s = id_valid & id_csr & (state_r != EXEC);
    assign busy = (state_r != IDLE) | ~sb_empty_s;

    // Pipeline control with freeze > redirect > interlock > issue priority.
    always_comb begin
        if_stall  = 1'b0;
        id_stall  = 1'b0;
        ex_bubble = 1'b0;
        id_flush  = 1'b0;
        csr_go    = 1'b0;
        issue_s   = 1'b0;
        if (mem_busy) begin
            if_stall = 1'b1;
            id_stall = 1'b1;
        end else if (ex_redirect) begin
            id_flush  = 1'b1;
            ex_bubble = 1'b1;
        end else if (raw_s | csr_hold_s) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_bubble = 1'b1;
        end else begin
            issue_s = id_valid;
            csr_go  = id_valid & (state_r == EXEC);
        end
    end

    // Scoreboard: age every entry, reload on a writing issue (reload wins).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else if (!mem_busy) begin
            for (int i = 1; i < 32; i++) begin
                if (issue_s && id_wen && (id_rd == i[4:0])) begin
                    cnt_r[i] <= CNT_LAT;
                end else if (pend_s[i]) begin
                    cnt_r[i] <= cnt_r[i] - CNT_ONE;
                end
            end
        end
    end

    // CSR serialization next-state; a freeze holds the state in every case.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (id_valid && id_csr && !mem_busy && !ex_redirect) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DRAIN: begin
                if (mem_busy) begin
                    state_nxt_s = DRAIN;
                end else if (ex_redirect || !id_valid) begin
                    state_nxt_s = IDLE;
                end else if (sb_empty_s) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            EXEC: begin
                if (mem_busy) begin
                    state_nxt_s = EXEC;
                end else if (ex_redirect || csr_go) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = EXEC;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched (LAT=3): per-cycle vector table plus a
// hand-written asynchronous-reset-during-drain sequence.
module tb_hazard_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] id_rd;
    logic       id_wen;
    logic       id_csr;
    logic       ex_redirect;
    logic       mem_busy;
    logic       if_stall;
    logic       id_stall;
    logic       ex_bubble;
    logic       id_flush;
    logic       csr_go;
    logic       busy;

    hazard_sched #(.LAT(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_wen      (id_wen),
        .id_csr      (id_csr),
        .ex_redirect (ex_redirect),
        .mem_busy    (mem_busy),
        .if_stall    (if_stall),
        .id_stall    (id_stall),
        .ex_bubble   (ex_bubble),
        .id_flush    (id_flush),
        .csr_go      (csr_go),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Observed outputs: {if_stall, id_stall, ex_bubble, id_flush, csr_go, busy}
    logic [5:0] got;
    assign got = {if_stall, id_stall, ex_bubble, id_flush, csr_go, busy};

    typedef struct {
        logic       valid;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       wen;
        logic       csr;
        logic       redir;
        logic       mb;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs [64];
    int   nv = 0;
    int   tests = 0;
    int   failed = 0;

    task automatic add(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                       input logic wen, input logic csr, input logic redir,
                       input logic mb, input logic [5:0] exp);
        vecs[nv].valid = v;   vecs[nv].rs1 = r1;   vecs[nv].u1 = u1;
        vecs[nv].rs2 = r2;    vecs[nv].u2 = u2;    vecs[nv].rd = rd;
        vecs[nv].wen = wen;   vecs[nv].csr = csr;  vecs[nv].redir = redir;
        vecs[nv].mb = mb;     vecs[nv].exp = exp;
        nv++;
    endtask

    task automatic drive(input vec_t v);
        id_valid = v.valid;  id_rs1 = v.rs1;  id_rs1_used = v.u1;
        id_rs2 = v.rs2;      id_rs2_used = v.u2;  id_rd = v.rd;
        id_wen = v.wen;      id_csr = v.csr;  ex_redirect = v.redir;
        mem_busy = v.mb;
    endtask

    task automatic check(input string name, input logic [5:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %b expected %b (if,id,bub,flush,go,busy)",
                     name, got, exp);
        end
    endtask

    // Sample mid-cycle, then advance to just after the next rising edge.
    task automatic step(input string name, input logic [5:0] exp);
        @(negedge clk);
        check(name, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t idle_v;
        idle_v = '{valid: 1'b0, rs1: 5'd0, u1: 1'b0, rs2: 5'd0, u2: 1'b0,
                   rd: 5'd0, wen: 1'b0, csr: 1'b0, redir: 1'b0, mb: 1'b0,
                   exp: 6'b000000};

        // valid rs1 u1 rs2 u2 rd wen csr redir mb   expected
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000);   // 0 idle after reset
        add(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 6'b000000);   // 1 write x5
        add(1, 5, 1, 0, 0, 10, 0, 0, 0, 0, 6'b111001);  // 2 reader stalls
        add(1, 5, 1, 0, 0, 10, 0, 0, 0, 0, 6'b111001);  // 3
        add(1, 5, 1, 0, 0, 10, 0, 0, 0, 0, 6'b111001);  // 4
        add(1, 5, 1, 0, 0, 10, 0, 0, 0, 0, 6'b000000);  // 5 issues in cycle 4
        add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b000000);   // 6 write x0
        add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 6'b000000);   // 7 read x0: no stall
        add(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 6'b000000);   // 8 write x7
        add(1, 8, 1, 9, 1, 0, 0, 0, 0, 0, 6'b000001);   // 9 unrelated
        add(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 6'b111001);   // 10 rs2 reader
        add(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 6'b111001);   // 11
        add(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 6'b000000);   // 12 2 stalls only
        add(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 6'b000000);   // 13 write x7
        add(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 6'b000001);   // 14 rewrite x7 reloads
        add(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 6'b111001);   // 15
        add(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 6'b111001);   // 16
        add(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 6'b111001);   // 17
        add(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 6'b000000);   // 18
        add(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 6'b000000);  // 19 write x12
        add(1, 12, 1, 0, 0, 13, 1, 0, 0, 0, 6'b111001); // 20 reader writes x13
        add(1, 12, 1, 0, 0, 13, 1, 0, 1, 0, 6'b001101); // 21 redirect flushes
        add(1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 6'b000001);  // 22 x13 not pending
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000);   // 23 drained
        add(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 6'b000000);   // 24 write x3
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000001);   // 25 cnt3 -> 2
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b111001);   // 26 CSR in IDLE
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b111001);   // 27 DRAIN
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b111001);   // 28 DRAIN, empty
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b000011);   // 29 EXEC: csr_go
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000);   // 30 back to IDLE
        add(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 6'b000000);   // 31 write x9
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000001);   // 32 cnt9 -> 2
        add(1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 6'b110001);   // 33 frozen
        add(1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 6'b110001);   // 34
        add(1, 9, 1, 0, 0, 0, 0, 0, 1, 1, 6'b110001);   // 35 freeze beats redirect
        add(1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 6'b110001);   // 36
        add(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 6'b111001);   // 37 cnt9 still 2
        add(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 6'b111001);   // 38
        add(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 6'b000000);   // 39

        drive(idle_v);
        rst = 1'b1;
        @(negedge clk);
        check("reset", 6'b000000);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < nv; i++) begin
            drive(vecs[i]);
            step($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset asserted in DRAIN with x4 pending, CSR held in ID throughout.
        drive(idle_v);
        id_valid = 1'b1; id_rd = 5'd4; id_wen = 1'b1;
        step("rst_prod", 6'b000000);
        id_rd = 5'd0; id_wen = 1'b0; id_csr = 1'b1;
        step("rst_csr_idle", 6'b111001);
        @(negedge clk);
        check("rst_in_drain", 6'b111001);
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_clear", 6'b111000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("rst_reidle", 6'b111000);
        step("rst_redrain", 6'b111001);
        step("rst_exec_go", 6'b000011);
        drive(idle_v);
        step("rst_done", 6'b000000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
